spi_ram_arbiter: RTL and testbench

- Sits between the SPI slave's 10-bit command stream (rx_data/rx_valid, tx_data/tx_valid) and the single-port RAM.
- Decodes the SPI commands and holds the write and read address registers.
- Shares the one RAM port between the SPI path and a local host port using round-robin arbitration.
- Returns read data to the SPI slave (tx path) or to the host.

---
 rtl/spi_ram_arbiter_pkg.sv | 21 ++
 rtl/spi_ram_arbiter_rr_arb2.sv | 39 +++
 rtl/spi_ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_arbiter_pkg.sv
// Shared opcodes, FSM states and owner encoding
// for the SPI/host RAM arbiter.
package spi_ram_arbiter_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-requester round-robin picker; the last_owner
// register doubles as the owner of the access in flight.
module rr_arb2
  import spi_ram_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_spi,
  input  logic   req_host,
  input  logic   update,
  output owner_t owner
);

  owner_t last_owner;
  owner_t pick;

  always_comb begin
    pick = last_owner;
    unique case (1'b1)
      (req_spi && !req_host): pick = OWN_SPI;
      (req_host && !req_spi): pick = OWN_HOST;
      (req_spi && req_host):
        pick = (last_owner == OWN_HOST) ? OWN_SPI
                                        : OWN_HOST;
      default: pick = last_owner;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_HOST;
    end else if (update) begin
      last_owner <= pick;
    end
  end

  assign owner = last_owner;

endmodule

// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and round-robin sharing of one
// RAM port between the SPI path and a local host.
module spi_ram_arbiter
  import spi_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err_ovf
);

  state_t            state;
  owner_t            owner;
  logic              spi_pend;
  logic              spi_we;
  logic [DATA_W-1:0] spi_wdata;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              tx_late;
  logic [1:0]        op;
  logic              data_op;
  logic              grant;
  logic              cur_we;

  assign op      = rx_data[9:8];
  assign data_op = (op == OP_WR_DATA) ||
                   (op == OP_RD_DATA);
  assign grant   = (state == IDLE) &&
                   (spi_pend || host_req);
  assign cur_we  = (owner == OWN_SPI) ? spi_we
                                      : host_we;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_spi  (spi_pend),
    .req_host (host_req),
    .update   (grant),
    .owner    (owner)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    host_gnt  = 1'b0;
    if (state == ACCESS) begin
      ram_en = 1'b1;
      ram_we = cur_we;
      if (owner == OWN_SPI) begin
        ram_addr  = spi_we ? wr_addr : rd_addr;
        ram_wdata = spi_wdata;
      end else begin
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        host_gnt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      spi_pend    <= 1'b0;
      spi_we      <= 1'b0;
      spi_wdata   <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      err_ovf     <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_late     <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      tx_late     <= 1'b0;
      if (rx_valid) begin
        tx_valid <= 1'b0;
        if (op == OP_WR_ADDR) begin
          wr_addr <= ADDR_W'(rx_data[7:0]);
        end else if (op == OP_RD_ADDR) begin
          rd_addr <= ADDR_W'(rx_data[7:0]);
        end else if (data_op && spi_pend) begin
          err_ovf <= 1'b1;
        end else if (data_op) begin
          spi_pend  <= 1'b1;
          spi_we    <= (op == OP_WR_DATA);
          spi_wdata <= DATA_W'(rx_data[7:0]);
        end
      end
      // A read that collided with rx_valid posts one cycle late
      if (tx_late) begin
        tx_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (spi_pend || host_req) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (owner == OWN_SPI) begin
            spi_pend <= 1'b0;
          end
          state <= cur_we ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          state <= IDLE;
          if (owner == OWN_SPI) begin
            tx_data <= ram_rdata;
            if (rx_valid) begin
              tx_late <= 1'b1;
            end else begin
              tx_valid <= 1'b1;
            end
          end else begin
            host_rdata  <= ram_rdata;
            host_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a small
// single-port RAM model on the RAM side.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       err_ovf;

  logic [7:0] mem [256];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  spi_ram_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .err_ovf     (err_ovf)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_cmd(input logic [9:0] v);
    rx_data  = v;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic host_set(
    input logic       we,
    input logic [7:0] a,
    input logic [7:0] d
  );
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    rst_n = 1'b1;
    tick();

    // SPI write 0x5C to 0x2A
    spi_cmd(10'h02A);
    spi_cmd(10'h15C);
    check("w_idle_en", ram_en, 0);
    tick();
    check("w_en", ram_en, 1);
    check("w_we", ram_we, 1);
    check("w_addr", ram_addr, 8'h2A);
    check("w_wdata", ram_wdata, 8'h5C);
    tick();
    check("w_en_off", ram_en, 0);
    check("w_tx_valid", tx_valid, 0);
    check("w_err_ovf", err_ovf, 0);

    // SPI read of 0x2A
    spi_cmd(10'h22A);
    spi_cmd(10'h300);
    check("r_n1_en", ram_en, 0);
    tick();
    check("r_n2_en", ram_en, 1);
    check("r_n2_we", ram_we, 0);
    check("r_n2_addr", ram_addr, 8'h2A);
    tick();
    check("r_n3_txv", tx_valid, 0);
    tick();
    check("r_n4_txv", tx_valid, 1);
    check("r_n4_txd", tx_data, 8'h5C);
    tick();
    tick();
    check("r_hold_txv", tx_valid, 1);

    // Host write 0x07=0xA5 then host read
    host_set(1'b1, 8'h07, 8'hA5);
    tick();
    check("hw_gnt", host_gnt, 1);
    check("hw_we", ram_we, 1);
    host_req = 1'b0;
    tick();
    host_set(1'b0, 8'h07, 8'h00);
    tick();
    check("hr_gnt", host_gnt, 1);
    check("hr_addr", ram_addr, 8'h07);
    check("hr_we", ram_we, 0);
    host_req = 1'b0;
    tick();
    check("hr_rvalid_early", host_rvalid, 0);
    tick();
    check("hr_rvalid", host_rvalid, 1);
    check("hr_rdata", host_rdata, 8'hA5);
    check("hr_txv_kept", tx_valid, 1);
    check("hr_txd_kept", tx_data, 8'h5C);
    tick();
    check("hr_rvalid_pulse", host_rvalid, 0);
    spi_cmd(10'h000);
    check("rx_clears_txv", tx_valid, 0);

    // First conflict from reset: SPI wins
    do_reset();
    spi_cmd(10'h040);
    spi_cmd(10'h177);
    host_set(1'b1, 8'h10, 8'h33);
    tick();
    check("c1_spi_addr", ram_addr, 8'h40);
    check("c1_spi_wdata", ram_wdata, 8'h77);
    check("c1_no_gnt", host_gnt, 0);
    tick();
    check("c1_gap", ram_en, 0);
    tick();
    check("c1_host_gnt", host_gnt, 1);
    check("c1_host_addr", ram_addr, 8'h10);
    check("c1_host_wdata", ram_wdata, 8'h33);
    host_req = 1'b0;
    tick();

    // Lone SPI write, then a conflict: host wins
    spi_cmd(10'h111);
    tick();
    tick();
    spi_cmd(10'h122);
    host_set(1'b1, 8'h20, 8'h44);
    tick();
    check("c2_host_gnt", host_gnt, 1);
    check("c2_host_addr", ram_addr, 8'h20);
    host_req = 1'b0;
    tick();
    tick();
    check("c2_spi_addr", ram_addr, 8'h40);
    check("c2_spi_wdata", ram_wdata, 8'h22);
    check("c2_spi_no_gnt", host_gnt, 0);
    tick();

    // Overflow while the host holds the RAM
    host_set(1'b1, 8'h07, 8'hA5);
    tick();
    host_req = 1'b0;
    tick();
    spi_cmd(10'h050);
    host_set(1'b0, 8'h07, 8'h00);
    tick();
    check("ov_host_gnt", host_gnt, 1);
    host_req = 1'b0;
    spi_cmd(10'h1AA);
    check("ov_err_first", err_ovf, 0);
    spi_cmd(10'h1BB);
    check("ov_err", err_ovf, 1);
    check("ov_rvalid", host_rvalid, 1);
    check("ov_rdata", host_rdata, 8'hA5);
    tick();
    check("ov_spi_we", ram_we, 1);
    check("ov_spi_addr", ram_addr, 8'h50);
    check("ov_spi_wdata", ram_wdata, 8'hAA);
    tick();
    check("ov_single", ram_en, 0);
    spi_cmd(10'h250);
    spi_cmd(10'h300);
    tick();
    tick();
    tick();
    check("ov_rb_txv", tx_valid, 1);
    check("ov_rb_txd", tx_data, 8'hAA);
    check("ov_sticky", err_ovf, 1);

    // Reset during an SPI RD_WAIT
    spi_cmd(10'h300);
    tick();
    check("rr_access", ram_en, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rr_txv", tx_valid, 0);
    check("rr_txd", tx_data, 0);
    check("rr_err", err_ovf, 0);
    check("rr_ram_en", ram_en, 0);
    check("rr_rvalid", host_rvalid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_post_txv", tx_valid, 0);
      check("rr_post_rvalid", host_rvalid, 0);
      check("rr_post_en", ram_en, 0);
    end
    host_set(1'b1, 8'h30, 8'h01);
    tick();
    check("rr_idle_gnt", host_gnt, 1);
    host_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
